// File: rtl/blram_loader.sv
// blram_loader: 32-bit block RAM shared by a CPU port and a byte-stream image
// loader. The CPU is held off (cpu_hold=1) until a complete image has been
// written. Each image has a 4-byte header: start word address, then word count.
// The header is followed by the data words, least-significant byte first.
// Optional feature macro: LDR_CHECKSUM_EN. When it is defined, a trailing
// modulo-256 checksum byte is compared against the running sum of all header and
// data bytes. A mismatch parks the loader in ERR.
module blram_loader #(
  parameter int ADDR_LEN  = 14,
  parameter int MEM_DEPTH = 16384
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [ADDR_LEN-1:0] i_addr,
  input  logic [31:0]         i_ram_data_in,
  output logic [31:0]         o_ram_data_out,
  input  logic                ld_valid,
  input  logic [7:0]          ld_byte,
  output logic                ld_ready,
  output logic                cpu_hold,
  output logic                ld_done,
  output logic                ld_err
);

  typedef enum logic [3:0] {
    HDR0,
    HDR1,
    HDR2,
    HDR3,
    DATA,
    WRITE,
`ifdef LDR_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

  // One extra bit so that MEM_DEPTH itself is representable for range checks.
  localparam logic [ADDR_LEN:0]   DEPTH     = (ADDR_LEN+1)'(MEM_DEPTH);
  localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(MEM_DEPTH - 1);

  logic [31:0] mem [0:MEM_DEPTH-1];

  state_t              state;
  state_t              state_next;
  logic [ADDR_LEN-1:0] load_addr;
  logic [15:0]         word_cnt;
  logic [1:0]          byte_idx;
  logic [7:0]          addr_lo;
  logic [7:0]          cnt_lo;
  logic [23:0]         word_buf;
  logic [31:0]         wr_word;
  logic                ready_reg;
`ifdef LDR_CHECKSUM_EN
  logic [7:0]          csum_acc;
  logic                err_reg;
`endif

  logic        take;
  logic [15:0] hdr_addr;
  logic [15:0] hdr_cnt;
  logic        cpu_in_range;
  logic        load_in_range;
  logic        unused_hdr;

  // A byte moves whenever the source offers one and the loader is listening.
  assign take          = ld_valid & ready_reg;
  assign hdr_addr      = {ld_byte, addr_lo};
  assign hdr_cnt       = {ld_byte, cnt_lo};
  assign cpu_in_range  = ({1'b0, i_addr} < DEPTH);
  assign load_in_range = ({1'b0, load_addr} < DEPTH);
  // Address bits above ADDR_LEN are discarded by design.
  assign unused_hdr    = ^hdr_addr;

  // The registered ready is masked while reset is asserted so no byte appears accepted.
  assign ld_ready = ready_reg & rst;

`ifdef LDR_CHECKSUM_EN
  assign ld_err = err_reg;
`else
  assign ld_err = 1'b0;
`endif

  // Next-state decode for the loader FSM.
  always_comb begin
    state_next = state;
    case (state)
      HDR0:  if (take) state_next = HDR1;
      HDR1:  if (take) state_next = HDR2;
      HDR2:  if (take) state_next = HDR3;
      HDR3:  if (take) state_next = (hdr_cnt == 16'd0) ? DONE : DATA;
      DATA:  if (take && byte_idx == 2'd3) state_next = WRITE;
      WRITE: begin
        if (word_cnt != 16'd1) begin
          state_next = DATA;
        end else begin
`ifdef LDR_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef LDR_CHECKSUM_EN
      CSUM:  if (take) state_next = (ld_byte == csum_acc) ? DONE : ERR;
`endif
      default: state_next = state;
    endcase
  end

  // Loader FSM, header/word datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= HDR0;
      load_addr <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      addr_lo   <= '0;
      cnt_lo    <= '0;
      word_buf  <= '0;
      wr_word   <= '0;
      ready_reg <= 1'b1;
      cpu_hold  <= 1'b1;
      ld_done   <= 1'b0;
`ifdef LDR_CHECKSUM_EN
      csum_acc  <= '0;
      err_reg   <= 1'b0;
`endif
    end else begin
      state <= state_next;

      case (state)
        HDR0: if (take) addr_lo <= ld_byte;
        HDR1: if (take) load_addr <= hdr_addr[ADDR_LEN-1:0];
        HDR2: if (take) cnt_lo <= ld_byte;
        HDR3: if (take) word_cnt <= hdr_cnt;
        DATA: begin
          if (take) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    word_buf[7:0]   <= ld_byte;
              2'd1:    word_buf[15:8]  <= ld_byte;
              2'd2:    word_buf[23:16] <= ld_byte;
              default: wr_word         <= {ld_byte, word_buf};
            endcase
          end
        end
        WRITE: begin
          word_cnt  <= word_cnt - 16'd1;
          load_addr <= (load_addr == LAST_ADDR) ? '0 : load_addr + 1'b1;
        end
        default: ;
      endcase

`ifdef LDR_CHECKSUM_EN
      // The running sum covers every header and data byte, but not the checksum byte itself.
      if (take && state != CSUM) csum_acc <= csum_acc + ld_byte;
      err_reg <= (state_next == ERR);
`endif

      // Status outputs are decoded from the upcoming state, so they stay aligned with it.
      ready_reg <= (state_next == HDR0) || (state_next == HDR1) ||
                   (state_next == HDR2) || (state_next == HDR3) ||
`ifdef LDR_CHECKSUM_EN
                   (state_next == CSUM) ||
`endif
                   (state_next == DATA);
      cpu_hold  <= (state_next != DONE);
      ld_done   <= (state_next == DONE);
    end
  end

  // Single RAM write port: loader words during WRITE, CPU writes only once released.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == WRITE) begin
        if (load_in_range) mem[load_addr] <= wr_word;
      end else if (!cpu_hold && i_we && cpu_in_range) begin
        mem[i_addr] <= i_ram_data_in;
      end
    end
  end

  // Registered CPU read; read-before-write, so same-address collisions return old data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_ram_data_out <= '0;
    end else if (cpu_hold || !cpu_in_range) begin
      o_ram_data_out <= '0;
    end else begin
      o_ram_data_out <= mem[i_addr];
    end
  end

endmodule

// File: tb/tb_blram_loader.sv
// tb_blram_loader: directed test of blram_loader. The default build has the
// checksum feature disabled; the LDR_CHECKSUM_EN paths append and check checksum bytes.
module tb_blram_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_we = 1'b0;
  logic [13:0] i_addr = '0;
  logic [31:0] i_ram_data_in = '0;
  logic [31:0] o_ram_data_out;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic        ld_ready;
  logic        cpu_hold;
  logic        ld_done;
  logic        ld_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  csum = '0;

  blram_loader #(.ADDR_LEN(14), .MEM_DEPTH(16384)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_we           (i_we),
    .i_addr         (i_addr),
    .i_ram_data_in  (i_ram_data_in),
    .o_ram_data_out (o_ram_data_out),
    .ld_valid       (ld_valid),
    .ld_byte        (ld_byte),
    .ld_ready       (ld_ready),
    .cpu_hold       (cpu_hold),
    .ld_done        (ld_done),
    .ld_err         (ld_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("check %-16s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0; i_we = 1'b0; ld_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", 32'(ld_ready), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(ld_done), 32'd0);
    check("rst_err", 32'(ld_err), 32'd0);
    check("rst_rdata", o_ram_data_out, 32'd0);
    rst = 1'b1;
    #1;
    check("post_rst_ready", 32'(ld_ready), 32'd1);
    csum = '0;
  endtask

  // Offer one byte (optionally after an idle cycle) and hold it until it transfers.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int waited;
    waited = 0;
    if (gap) begin
      ld_valid = 1'b0;
      @(posedge clk); #1;
    end
    ld_valid = 1'b1;
    ld_byte  = b;
    while (ld_ready !== 1'b1 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (ld_ready !== 1'b1) check("ready_timeout", 32'(ld_ready), 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    csum = csum + b;
  endtask

`ifdef LDR_CHECKSUM_EN
  task automatic send_csum(input logic [7:0] delta);
    logic [7:0] v;
    v = csum + delta;
    send_byte(v, 1'b0);
  endtask
`endif

  task automatic wait_end();
    int waited;
    waited = 0;
    while (ld_done !== 1'b1 && ld_err !== 1'b1 && waited < 60) begin
      @(posedge clk); #1;
      waited++;
    end
    check("load_done", 32'(ld_done), 32'd1);
  endtask

  task automatic rd(input string tag, input logic [13:0] a, input logic [31:0] exp);
    i_we = 1'b0; i_addr = a;
    @(posedge clk); #1;
    check(tag, o_ram_data_out, exp);
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    i_we = 1'b1; i_addr = a; i_ram_data_in = d;
    @(posedge clk); #1;
    i_we = 1'b0;
  endtask

  initial begin
    // Power-up reset.
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Two-word image at word 100, continuous valid.
    send_byte(8'h64, 0); send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    check("write_ready", 32'(ld_ready), 32'd0);
    check("write_done", 32'(ld_done), 32'd0);
    @(posedge clk); #1;
`ifdef LDR_CHECKSUM_EN
    check("csum_ready", 32'(ld_ready), 32'd1);
    send_csum(8'd0);
`endif
    check("after_wr_done", 32'(ld_done), 32'd1);
    check("after_wr_hold", 32'(cpu_hold), 32'd0);
    check("done_ready", 32'(ld_ready), 32'd0);
    rd("mem100", 14'd100, 32'd2);
    rd("mem101", 14'd101, 32'd5);

    // CPU write, read back, then same-cycle write/read collision.
    wr(14'd110, 32'hFFFF_FFFF);
    rd("mem110_wr", 14'd110, 32'hFFFF_FFFF);
    i_we = 1'b1; i_addr = 14'd110; i_ram_data_in = 32'h0;
    @(posedge clk); #1;
    check("rdw_old", o_ram_data_out, 32'hFFFF_FFFF);
    i_we = 1'b0;
    rd("mem110_new", 14'd110, 32'h0);

    // Reload with an empty image; CPU writes during hold are ignored.
    do_reset();
    i_we = 1'b1; i_addr = 14'd110; i_ram_data_in = 32'h1234_5678;
    send_byte(8'h64, 0);
    check("hold_rdata", o_ram_data_out, 32'd0);
    send_byte(8'h00, 0);
    i_we = 1'b0;
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    check("n0_done", 32'(ld_done), 32'd1);
    check("n0_hold", 32'(cpu_hold), 32'd0);
    ld_valid = 1'b1; ld_byte = 8'hAA;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    check("term_ready", 32'(ld_ready), 32'd0);
    check("term_done", 32'(ld_done), 32'd1);
    rd("n0_mem100", 14'd100, 32'd2);
    rd("n0_mem101", 14'd101, 32'd5);
    rd("hold_wr_drop", 14'd110, 32'd0);

    // Address wrap at the top of memory, valid toggled every cycle.
    do_reset();
    send_byte(8'hFF, 1); send_byte(8'h3F, 1); send_byte(8'h02, 1); send_byte(8'h00, 1);
    send_byte(8'h44, 1); send_byte(8'h33, 1); send_byte(8'h22, 1); send_byte(8'h11, 1);
    send_byte(8'hDD, 1); send_byte(8'hCC, 1); send_byte(8'hBB, 1); send_byte(8'hAA, 1);
`ifdef LDR_CHECKSUM_EN
    send_csum(8'd0);
`endif
    wait_end();
    rd("wrap_top", 14'd16383, 32'h1122_3344);
    rd("wrap_zero", 14'd0, 32'hAABB_CCDD);

    // Reset in the middle of a word aimed at word 100.
    do_reset();
    send_byte(8'h64, 0); send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h77, 0); send_byte(8'h77, 0);
    do_reset();
    check("mid_rst_done", 32'(ld_done), 32'd0);
    check("mid_rst_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    check("mid_n0_done", 32'(ld_done), 32'd1);
    rd("mid_mem100", 14'd100, 32'd2);
    check("err_low", 32'(ld_err), 32'd0);

`ifdef LDR_CHECKSUM_EN
    // Corrupted checksum byte must end in ERR with the CPU still held.
    do_reset();
    send_byte(8'h2C, 0); send_byte(8'h01, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_csum(8'd1);
    check("bad_err", 32'(ld_err), 32'd1);
    check("bad_hold", 32'(cpu_hold), 32'd1);
    check("bad_ready", 32'(ld_ready), 32'd0);
    check("bad_done", 32'(ld_done), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/blram_loader.md
BLRAM_LOADER -- requirements
Module: blram_loader

Interface
REQ-001 Parameter ADDR_LEN, default 14, word-address width of both ports.
REQ-002 Parameter MEM_DEPTH, default 16384, number of 32-bit memory words.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 i_we  input  1  CPU write enable.
REQ-006 i_addr  input  ADDR_LEN  CPU word address.
REQ-007 i_ram_data_in  input  32  CPU write data.
REQ-008 o_ram_data_out  output  32  CPU read data, registered.
REQ-009 ld_valid  input  1  loader byte valid.
REQ-010 ld_byte  input  8  loader byte.
REQ-011 ld_ready  output  1  loader byte accept; a byte transfers on an edge with ld_valid=1 and ld_ready=1.
REQ-012 cpu_hold  output  1  holds the CPU in reset while the image is loading.
REQ-013 ld_done  output  1  image load completed successfully.
REQ-014 ld_err  output  1  image load failed.

Function
REQ-015 The loader stream SHALL be: ADDR_LO, ADDR_HI (16-bit start word address; bits above ADDR_LEN ignored), CNT_LO, CNT_HI (16-bit word count N), then 4N data bytes, little-endian per word.
REQ-016 FSM states SHALL be HDR0, HDR1, HDR2, HDR3, DATA, WRITE, CSUM, DONE and ERR; HDR0..HDR3 advance one state per accepted byte.
REQ-017 On HDR3 acceptance, the FSM SHALL go to DONE if N=0 and to DATA otherwise.
REQ-018 DATA SHALL collect 4 bytes; acceptance of the 4th byte SHALL move the FSM to WRITE.
REQ-019 WRITE SHALL last exactly 1 cycle and write the assembled word to mem[load_addr].
REQ-020 In WRITE, load_addr SHALL increment, wrapping from MEM_DEPTH-1 to 0.
REQ-021 After WRITE, the FSM SHALL return to DATA if words remain; after the last word it SHALL go to CSUM if the checksum feature is compiled in, otherwise to DONE.
REQ-022 ld_ready SHALL be 1 in HDR0..HDR3, DATA and CSUM, and 0 in WRITE, DONE and ERR, and while rst=0.
REQ-023 When ld_valid=0, the FSM SHALL hold state and partial data indefinitely.
REQ-024 cpu_hold SHALL be 1 in every state except DONE; ld_done SHALL be 1 only in DONE; ld_err SHALL be 1 only in ERR.
REQ-025 DONE and ERR SHALL be terminal until reset, and further loader bytes SHALL be ignored.
REQ-026 When cpu_hold=0, every edge SHALL register o_ram_data_out <= mem[i_addr], a read latency of 1 cycle.
REQ-027 A CPU read and write to the same address in the same cycle SHALL return the old data.
REQ-028 When cpu_hold=0 and i_we=1, the block SHALL write mem[i_addr] <= i_ram_data_in.
REQ-029 When cpu_hold=1, CPU writes SHALL be ignored and o_ram_data_out SHALL be 0.
REQ-030 For i_addr >= MEM_DEPTH, CPU writes SHALL be dropped and reads SHALL return 0.

Reset
REQ-031 rst=0 at an edge SHALL set: FSM=HDR0, load_addr=0, word count=0, byte index=0, checksum accumulator=0, o_ram_data_out=0, cpu_hold=1, ld_done=0, ld_err=0.
REQ-032 Reset mid-load SHALL discard the partial header/word; words already written SHALL remain; memory is never cleared by reset.

Configuration
REQ-033 Macro LDR_CHECKSUM_EN: when defined, CSUM SHALL accept 1 byte and compare it with the 8-bit modulo-256 sum of all header and data bytes; a match SHALL go to DONE, a mismatch SHALL go to ERR with cpu_hold kept at 1.
REQ-034 Without LDR_CHECKSUM_EN, the CSUM state and accumulator SHALL not exist, and ld_err SHALL be constant 0.

Verification
REQ-035 Stream 64,00,02,00,02,00,00,00,05,00,00,00 -> mem[100]=2, mem[101]=5; ld_done=1 and cpu_hold=0 the cycle after the 2nd WRITE (macro off).
REQ-036 Header with N=0 -> DONE directly after the 4th byte; memory unchanged.
REQ-037 After DONE: CPU write addr 110 data 0xFFFFFFFF, then read addr 110 -> o_ram_data_out=0xFFFFFFFF one cycle later; simultaneous write 0 and read of addr 110 -> returns 0xFFFFFFFF.
REQ-038 Start address 16383, N=2 -> words land at mem[16383] and mem[0].
REQ-039 ld_valid toggled 0/1 every cycle during the stream -> same memory result as continuous valid; rst=0 after 6 bytes -> FSM=HDR0, ld_done=0, target words unchanged.
REQ-040 LDR_CHECKSUM_EN defined: correct checksum byte -> ld_done=1; checksum byte+1 -> ld_err=1, cpu_hold stays 1, ld_ready=0.
